data_io_loader: RTL and testbench

DATA_IO_LOADER -- requirements
Module: data_io

---
 rtl/data_io_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_data_io_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_loader.sv
// data_io_loader
//   SPI-fed file loader for an IO controller. Bytes arriving on SPI_SS2
//   form command transactions (first byte = command, rest = payload) that
//   set the file index/extension, open and close downloads, stream download
//   data onto the ioctl_* write port, and stream upload data back out on
//   SPI_DO. With ROM_DIRECT_UPLOAD=1, every byte received on SPI_SS4 while a
//   download is open is also treated as download data.
//
// Ports
//   clk_sys         system clock (>= 4x SPI_SCK), all logic on rising edge
//   rst             synchronous active-high reset
//   SPI_SCK/DI      asynchronous SPI clock/data in (mode 0, MSB first)
//   SPI_SS2/SS4     asynchronous active-low selects
//   SPI_DO          SPI data out, high impedance unless an upload is active
//   clkref_n        write qualifier, ioctl_wr only fires while low
//   ioctl_din       upload byte for the current ioctl_addr
//   ioctl_download  download in progress
//   ioctl_upload    upload in progress
//   ioctl_index     file index
//   ioctl_fileext   file extension (last three bytes received)
//   ioctl_filesize  byte count of the last completed download
//   ioctl_addr      transfer address
//   ioctl_dout      downloaded byte
//   ioctl_wr        one-cycle write strobe
module data_io_loader #(
  parameter logic ROM_DIRECT_UPLOAD = 1'b0
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        SPI_SCK,
  input  logic        SPI_DI,
  input  logic        SPI_SS2,
  input  logic        SPI_SS4,
  inout  wire         SPI_DO,
  input  logic        clkref_n,
  input  logic [7:0]  ioctl_din,
  output logic        ioctl_download,
  output logic        ioctl_upload,
  output logic [7:0]  ioctl_index,
  output logic [23:0] ioctl_fileext,
  output logic [31:0] ioctl_filesize,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic        ioctl_wr
);

  localparam logic [7:0] CMD_DOWNLOAD    = 8'h50;
  localparam logic [7:0] CMD_DL_DATA     = 8'h53;
  localparam logic [7:0] CMD_INDEX       = 8'h54;
  localparam logic [7:0] CMD_FILEEXT     = 8'h55;
  localparam logic [7:0] CMD_UPLOAD      = 8'h56;
  localparam logic [7:0] CMD_UL_DATA     = 8'h57;

  // Bit order {SS4, SS2, DI, SCK}; selects idle high so reset them high.
  localparam logic [3:0] SYNC_INIT = 4'b1100;

  logic [3:0] spi_raw;
  logic [3:0] spi_sync;

  assign spi_raw = {SPI_SS4, SPI_SS2, SPI_DI, SPI_SCK};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk_sys) begin
        if (rst) begin
          meta_reg <= SYNC_INIT[gi];
          sync_reg <= SYNC_INIT[gi];
        end else begin
          meta_reg <= spi_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign spi_sync[gi] = sync_reg;
    end
  endgenerate

  logic sck_s, di_s, ss2_s, ss4_s;
  assign sck_s = spi_sync[0];
  assign di_s  = spi_sync[1];
  assign ss2_s = spi_sync[2];
  assign ss4_s = spi_sync[3];

  logic        sck_prev_reg;
  logic [2:0]  bit_cnt_reg;
  logic [6:0]  shift_reg;
  logic [7:0]  cmd_reg;
  logic        cmd_valid_reg;
  logic        first_reg;
  logic [7:0]  data_reg;
  logic        pending_reg;
  logic [31:0] count_reg;
  logic [6:0]  tx_reg;
  logic        do_reg;

  logic        download_reg;
  logic        upload_reg;
  logic [7:0]  index_reg;
  logic [23:0] fileext_reg;
  logic [31:0] filesize_reg;
  logic [24:0] addr_reg;
  logic [7:0]  dout_reg;
  logic        wr_reg;

  logic       sck_rise, sck_fall, sel, byte_done, tx_active;
  logic [7:0] rx_byte;

  assign sck_rise  = sck_s & ~sck_prev_reg;
  assign sck_fall  = ~sck_s & sck_prev_reg;
  // SS4 only takes part in byte assembly when the direct path is enabled.
  assign sel       = ~ss2_s | (ROM_DIRECT_UPLOAD & ~ss4_s);
  assign byte_done = sel & sck_rise & (bit_cnt_reg == 3'd7);
  assign rx_byte   = {shift_reg, di_s};
  assign tx_active = cmd_valid_reg & (cmd_reg == CMD_UL_DATA) & upload_reg;

  assign SPI_DO = (~ss2_s & tx_active) ? do_reg : 1'bz;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sck_prev_reg  <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 7'd0;
      cmd_reg       <= 8'd0;
      cmd_valid_reg <= 1'b0;
      first_reg     <= 1'b0;
      data_reg      <= 8'd0;
      pending_reg   <= 1'b0;
      count_reg     <= 32'd0;
      tx_reg        <= 7'd0;
      do_reg        <= 1'b0;
      download_reg  <= 1'b0;
      upload_reg    <= 1'b0;
      index_reg     <= 8'd0;
      fileext_reg   <= 24'd0;
      filesize_reg  <= 32'd0;
      addr_reg      <= 25'd0;
      dout_reg      <= 8'd0;
      wr_reg        <= 1'b0;
    end else begin
      sck_prev_reg <= sck_s;

      // Byte assembly; a deselect throws away any partial byte.
      if (!sel) begin
        bit_cnt_reg <= 3'd0;
      end else if (sck_rise) begin
        shift_reg   <= {shift_reg[5:0], di_s};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end

      if (ss2_s) begin
        cmd_valid_reg <= 1'b0;
      end

      // Write strobe: the address advances in the cycle after the pulse,
      // so the pulse itself presents the pre-increment address.
      wr_reg <= 1'b0;
      if (wr_reg) begin
        addr_reg  <= addr_reg + 25'd1;
        count_reg <= count_reg + 32'd1;
      end
      if (pending_reg && !clkref_n) begin
        wr_reg      <= 1'b1;
        dout_reg    <= data_reg;
        pending_reg <= 1'b0;
      end

      // Upload shifter. The SCK fall that starts a byte (bit counter back
      // at 0) samples ioctl_din; this is several cycles after the address
      // moved on the preceding rise, giving the upstream memory time.
      if (sck_fall && !ss2_s && tx_active) begin
        if (bit_cnt_reg == 3'd0) begin
          do_reg <= ioctl_din[7];
          tx_reg <= ioctl_din[6:0];
        end else begin
          do_reg <= tx_reg[6];
          tx_reg <= {tx_reg[5:0], 1'b0};
        end
      end

      if (byte_done) begin
        if (!ss2_s) begin
          if (!cmd_valid_reg) begin
            cmd_reg       <= rx_byte;
            cmd_valid_reg <= 1'b1;
            first_reg     <= 1'b1;
          end else begin
            first_reg <= 1'b0;
            case (cmd_reg)
              CMD_INDEX: begin
                if (first_reg) index_reg <= rx_byte;
              end
              CMD_FILEEXT: begin
                fileext_reg <= {fileext_reg[15:0], rx_byte};
              end
              CMD_DOWNLOAD: begin
                if (rx_byte != 8'h00) begin
                  download_reg <= 1'b1;
                  addr_reg     <= 25'd0;
                  count_reg    <= 32'd0;
                end else begin
                  download_reg <= 1'b0;
                  filesize_reg <= count_reg;
                end
              end
              CMD_DL_DATA: begin
                if (download_reg) begin
                  data_reg    <= rx_byte;
                  pending_reg <= 1'b1;
                end
              end
              CMD_UPLOAD: begin
                if (rx_byte != 8'h00) begin
                  upload_reg <= 1'b1;
                  addr_reg   <= 25'd0;
                end else begin
                  upload_reg <= 1'b0;
                end
              end
              CMD_UL_DATA: begin
                if (upload_reg) addr_reg <= addr_reg + 25'd1;
              end
              default: ;
            endcase
          end
        end else if (download_reg) begin
          // Reachable only through SS4 with the direct path enabled.
          data_reg    <= rx_byte;
          pending_reg <= 1'b1;
        end
      end
    end
  end

  assign ioctl_download = download_reg;
  assign ioctl_upload   = upload_reg;
  assign ioctl_index    = index_reg;
  assign ioctl_fileext  = fileext_reg;
  assign ioctl_filesize = filesize_reg;
  assign ioctl_addr     = addr_reg;
  assign ioctl_dout     = dout_reg;
  assign ioctl_wr       = wr_reg;

endmodule

// File: tb/tb_data_io_loader.sv
// Testbench for data_io_loader: directed SPI transactions against a
// direct-path instance (ROM_DIRECT_UPLOAD=1) and a plain instance.
module tb_data_io_loader;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_di = 1'b0;
  logic        spi_ss2 = 1'b1;
  logic        spi_ss4 = 1'b1;
  logic        clkref_n = 1'b0;
  logic [7:0]  ioctl_din;
  wire         spi_do;
  wire         spi_do0;

  logic        ioctl_download, ioctl_upload, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [23:0] ioctl_fileext;
  logic [31:0] ioctl_filesize;
  logic [24:0] ioctl_addr;

  logic        dl0, ul0, wr0;
  logic [7:0]  index0, dout0;
  logic [23:0] ext0;
  logic [31:0] size0;
  logic [24:0] addr0;
  logic [7:0]  din0 = 8'h00;

  pullup (spi_do);
  pullup (spi_do0);

  always #5 clk_sys = ~clk_sys;

  data_io_loader #(.ROM_DIRECT_UPLOAD(1'b1)) dut (
    .clk_sys(clk_sys), .rst(rst), .SPI_SCK(spi_sck), .SPI_DI(spi_di),
    .SPI_SS2(spi_ss2), .SPI_SS4(spi_ss4), .SPI_DO(spi_do), .clkref_n(clkref_n),
    .ioctl_din(ioctl_din), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_fileext(ioctl_fileext), .ioctl_filesize(ioctl_filesize),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr)
  );

  data_io_loader #(.ROM_DIRECT_UPLOAD(1'b0)) dut0 (
    .clk_sys(clk_sys), .rst(rst), .SPI_SCK(spi_sck), .SPI_DI(spi_di),
    .SPI_SS2(spi_ss2), .SPI_SS4(spi_ss4), .SPI_DO(spi_do0), .clkref_n(clkref_n),
    .ioctl_din(din0), .ioctl_download(dl0), .ioctl_upload(ul0),
    .ioctl_index(index0), .ioctl_fileext(ext0), .ioctl_filesize(size0),
    .ioctl_addr(addr0), .ioctl_dout(dout0), .ioctl_wr(wr0)
  );

  // Upload memory: 0x5A at 0, 0xA5 at 1, zero elsewhere.
  always_comb begin
    ioctl_din = 8'h00;
    if (ioctl_addr == 25'd0) ioctl_din = 8'h5A;
    else if (ioctl_addr == 25'd1) ioctl_din = 8'hA5;
  end

  // Write monitor: records every strobe and counts strobes longer than a cycle.
  int          wr_cnt = 0;
  int          wr_long = 0;
  int          wr0_cnt = 0;
  logic        wr_prev = 1'b0;
  logic [24:0] wr_addr [16];
  logic [7:0]  wr_data [16];

  always @(negedge clk_sys) begin
    if (ioctl_wr) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = ioctl_addr;
        wr_data[wr_cnt] = ioctl_dout;
      end
      wr_cnt++;
      if (wr_prev) wr_long++;
    end
    wr_prev = ioctl_wr;
    if (wr0) wr0_cnt++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Mode 0: DI set while SCK low, DO sampled just before the rise.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_di = tx[i];
      tick(4);
      rx[i] = spi_do;
      spi_sck = 1'b1;
      tick(4);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] unused_rx;
    spi_xfer(b, 8, unused_rx);
  endtask

  task automatic ss2_begin();
    spi_ss2 = 1'b0;
    tick(4);
  endtask

  task automatic ss2_end();
    tick(4);
    spi_ss2 = 1'b1;
    tick(6);
  endtask

  task automatic cmd1(input logic [7:0] c, input logic [7:0] p);
    ss2_begin();
    send(c);
    send(p);
    ss2_end();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base0;
    logic [7:0] rx;

    tick(5);
    check("rst_download", {31'd0, ioctl_download}, 32'd0);
    check("rst_upload",   {31'd0, ioctl_upload}, 32'd0);
    check("rst_wr",       {31'd0, ioctl_wr}, 32'd0);
    check("rst_index",    {24'd0, ioctl_index}, 32'd0);
    check("rst_fileext",  {8'd0, ioctl_fileext}, 32'd0);
    check("rst_filesize", ioctl_filesize, 32'd0);
    check("rst_addr",     {7'd0, ioctl_addr}, 32'd0);
    check("rst_dout",     {24'd0, ioctl_dout}, 32'd0);
    check("rst_do_hiz",   {31'd0, spi_do}, 32'd1);
    rst = 1'b0;
    tick(4);

    // File index.
    cmd1(8'h54, 8'h02);
    check("index", {24'd0, ioctl_index}, 32'h02);
    check("index_no_wr", wr_cnt, 0);

    // File extension keeps the last three bytes.
    ss2_begin();
    send(8'h55); send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    ss2_end();
    check("fileext", {8'd0, ioctl_fileext}, 32'h424344);

    // Unknown command with payload is ignored.
    ss2_begin();
    send(8'h99); send(8'h12); send(8'h34);
    ss2_end();
    check("unk_index", {24'd0, ioctl_index}, 32'h02);
    check("unk_ext",   {8'd0, ioctl_fileext}, 32'h424344);
    check("unk_dl",    {31'd0, ioctl_download}, 32'd0);

    // Download of three bytes.
    cmd1(8'h50, 8'h01);
    check("dl_start", {31'd0, ioctl_download}, 32'd1);
    check("dl_addr0", {7'd0, ioctl_addr}, 32'd0);
    ss2_begin();
    send(8'h53); send(8'hAA); send(8'hBB); send(8'hCC);
    ss2_end();
    cmd1(8'h50, 8'h00);
    check("dl_stop", {31'd0, ioctl_download}, 32'd0);
    check("dl_size", ioctl_filesize, 32'd3);
    check("dl_wrcnt", wr_cnt, 3);
    check("dl_w0", {wr_addr[0], wr_data[0]}, {25'd0, 8'hAA});
    check("dl_w1", {wr_addr[1], wr_data[1]}, {25'd1, 8'hBB});
    check("dl_w2", {wr_addr[2], wr_data[2]}, {25'd2, 8'hCC});
    check("dl_pulse_len", wr_long, 0);
    check("dl_addr_end", {7'd0, ioctl_addr}, 32'd3);

    // Restart of an active download, then a truncated data byte.
    cmd1(8'h50, 8'h01);
    cmd1(8'h53, 8'h77);
    check("rs_addr1", {7'd0, ioctl_addr}, 32'd1);
    check("rs_w3", {wr_addr[3], wr_data[3]}, {25'd0, 8'h77});
    cmd1(8'h50, 8'h01);
    check("rs_addr0", {7'd0, ioctl_addr}, 32'd0);
    base = wr_cnt;
    ss2_begin();
    send(8'h53);
    spi_xfer(8'hDE, 5, rx);
    ss2_end();
    check("part_no_wr", wr_cnt - base, 0);
    check("part_addr", {7'd0, ioctl_addr}, 32'd0);
    cmd1(8'h50, 8'h00);
    check("rs_size", ioctl_filesize, 32'd0);

    // Data with no download open is dropped.
    base = wr_cnt;
    cmd1(8'h53, 8'h66);
    check("nodl_no_wr", wr_cnt - base, 0);

    // SS4 direct path.
    cmd1(8'h50, 8'h01);
    base = wr_cnt;
    base0 = wr0_cnt;
    spi_ss4 = 1'b0;
    tick(4);
    send(8'h11); send(8'h22);
    tick(4);
    spi_ss4 = 1'b1;
    tick(6);
    check("ss4_wrcnt", wr_cnt - base, 2);
    check("ss4_w0", {wr_addr[base], wr_data[base]}, {25'd0, 8'h11});
    check("ss4_w1", {wr_addr[base + 1], wr_data[base + 1]}, {25'd1, 8'h22});
    check("ss4_off_no_wr", wr0_cnt - base0, 0);
    cmd1(8'h50, 8'h00);
    check("ss4_size", ioctl_filesize, 32'd2);

    // clkref_n holds a completed byte back.
    cmd1(8'h50, 8'h01);
    base = wr_cnt;
    clkref_n = 1'b1;
    ss2_begin();
    send(8'h53); send(8'h3C);
    tick(10);
    check("ref_held", wr_cnt - base, 0);
    clkref_n = 1'b0;
    tick(5);
    check("ref_one_wr", wr_cnt - base, 1);
    check("ref_w", {wr_addr[base], wr_data[base]}, {25'd0, 8'h3C});
    check("ref_pulse_len", wr_long, 0);
    ss2_end();
    cmd1(8'h50, 8'h00);

    // Upload of two bytes.
    cmd1(8'h56, 8'h01);
    check("ul_start", {31'd0, ioctl_upload}, 32'd1);
    check("ul_addr0", {7'd0, ioctl_addr}, 32'd0);
    ss2_begin();
    send(8'h57);
    spi_xfer(8'h00, 8, rx);
    check("ul_byte0", {24'd0, rx}, 32'h5A);
    spi_xfer(8'h00, 8, rx);
    check("ul_byte1", {24'd0, rx}, 32'hA5);
    ss2_end();
    check("ul_addr_end", {7'd0, ioctl_addr}, 32'd2);
    check("ul_do_hiz", {31'd0, spi_do}, 32'd1);
    cmd1(8'h56, 8'h00);
    check("ul_stop", {31'd0, ioctl_upload}, 32'd0);

    // Reset in the middle of a transaction.
    ss2_begin();
    send(8'h54);
    spi_xfer(8'hFF, 3, rx);
    rst = 1'b1;
    tick(2);
    spi_ss2 = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    check("mid_rst_index", {24'd0, ioctl_index}, 32'd0);
    check("mid_rst_ext", {8'd0, ioctl_fileext}, 32'd0);
    cmd1(8'h54, 8'h07);
    check("post_rst_index", {24'd0, ioctl_index}, 32'h07);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
